// File: rtl/mem_access_unit.sv
// Load/store alignment and sub-word merge in front of a word-addressed memory; loads return 1 cycle later.
// sb/sh read-modify-write over 2 cycles, stall high in the write cycle; misaligned/out-of-range accesses fault.
module mem_access_unit #(
   parameter int ADDR_W = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [5:0]  opcode,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        mem_fault,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_write_data,
   output logic        sig_mem_read,
   output logic        sig_mem_write,
   input  logic [31:0] mem_read_data
);

   typedef enum logic {IDLE, RMW} state_t;

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2B;

   state_t              state_q, state_d;
   logic [31:0]         load_data_q, load_data_d;
   logic                load_valid_q, load_valid_d;
   logic                mem_fault_q, mem_fault_d;
   logic [31:0]         merge_q, merge_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [1:0]          lane_q, lane_d;
   logic                half_q, half_d;
   logic [15:0]         sbytes_q, sbytes_d;

   logic                is_load, is_store, is_half, is_word, oor, misaligned;
   logic [ADDR_W-1:0]   idx, maddr;
   logic [7:0]          ld_byte;
   logic [15:0]         ld_half;
   logic [31:0]         ld_ext, merged, wdata;
   logic                rd, wr;

   assign idx        = addr[ADDR_W+1:2];
   assign oor        = |addr[31:ADDR_W+2];
   assign is_load    = (opcode == OP_LB) || (opcode == OP_LH) || (opcode == OP_LW) ||
                       (opcode == OP_LBU) || (opcode == OP_LHU);
   assign is_store   = (opcode == OP_SB) || (opcode == OP_SH) || (opcode == OP_SW);
   assign is_half    = (opcode == OP_LH) || (opcode == OP_LHU) || (opcode == OP_SH);
   assign is_word    = (opcode == OP_LW) || (opcode == OP_SW);
   assign misaligned = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));

   // Big-endian lanes: offset 0 is the most significant byte.
   always_comb begin
      ld_byte = mem_read_data[7:0];
      case (addr[1:0])
         2'd0: ld_byte = mem_read_data[31:24];
         2'd1: ld_byte = mem_read_data[23:16];
         2'd2: ld_byte = mem_read_data[15:8];
         default: ld_byte = mem_read_data[7:0];
      endcase
      ld_half = addr[1] ? mem_read_data[15:0] : mem_read_data[31:16];
      ld_ext  = mem_read_data;
      case (opcode)
         OP_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
         OP_LBU:  ld_ext = {24'h0, ld_byte};
         OP_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
         OP_LHU:  ld_ext = {16'h0, ld_half};
         default: ld_ext = mem_read_data;
      endcase
   end

   always_comb begin
      merged = merge_q;
      if (half_q) begin
         if (lane_q[1]) merged[15:0]  = sbytes_q;
         else           merged[31:16] = sbytes_q;
      end else begin
         case (lane_q)
            2'd0: merged[31:24] = sbytes_q[7:0];
            2'd1: merged[23:16] = sbytes_q[7:0];
            2'd2: merged[15:8]  = sbytes_q[7:0];
            default: merged[7:0] = sbytes_q[7:0];
         endcase
      end
   end

   always_comb begin
      state_d      = state_q;
      load_data_d  = load_data_q;
      load_valid_d = 1'b0;
      mem_fault_d  = 1'b0;
      merge_d      = merge_q;
      idx_d        = idx_q;
      lane_d       = lane_q;
      half_d       = half_q;
      sbytes_d     = sbytes_q;
      rd           = 1'b0;
      wr           = 1'b0;
      maddr        = '0;
      wdata        = '0;
      case (state_q)
         IDLE: begin
            if (req_valid && (is_load || is_store)) begin
               if (oor || misaligned) begin
                  mem_fault_d = 1'b1;
               end else if (is_load) begin
                  rd           = 1'b1;
                  maddr        = idx;
                  load_data_d  = ld_ext;
                  load_valid_d = 1'b1;
               end else if (is_word) begin
                  wr    = 1'b1;
                  maddr = idx;
                  wdata = store_data;
               end else begin
                  rd       = 1'b1;
                  maddr    = idx;
                  merge_d  = mem_read_data;
                  idx_d    = idx;
                  lane_d   = addr[1:0];
                  half_d   = is_half;
                  sbytes_d = store_data[15:0];
                  state_d  = RMW;
               end
            end
         end
         default: begin
            // The held request is ignored; only the captured store is written.
            wr      = 1'b1;
            maddr   = idx_q;
            wdata   = merged;
            state_d = IDLE;
         end
      endcase
      if (reset) begin
         rd    = 1'b0;
         wr    = 1'b0;
         maddr = '0;
         wdata = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         load_data_q  <= '0;
         load_valid_q <= 1'b0;
         mem_fault_q  <= 1'b0;
         merge_q      <= '0;
         idx_q        <= '0;
         lane_q       <= '0;
         half_q       <= 1'b0;
         sbytes_q     <= '0;
      end else begin
         state_q      <= state_d;
         load_data_q  <= load_data_d;
         load_valid_q <= load_valid_d;
         mem_fault_q  <= mem_fault_d;
         merge_q      <= merge_d;
         idx_q        <= idx_d;
         lane_q       <= lane_d;
         half_q       <= half_d;
         sbytes_q     <= sbytes_d;
      end
   end

   assign stall          = (state_q == RMW);
   assign load_data      = load_data_q;
   assign load_valid     = load_valid_q;
   assign mem_fault      = mem_fault_q;
   assign mem_addr       = {{(32-ADDR_W){1'b0}}, maddr};
   assign mem_write_data = wdata;
   assign sig_mem_read   = rd;
   assign sig_mem_write  = wr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-addressed big-endian reference memory predicts every cycle's outputs.
module tb_mem_access_unit;
   localparam int ADDR_W = 8;
   localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
   localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, req_valid, stall, load_valid, mem_fault, sig_mem_read, sig_mem_write;
   logic [5:0]  opcode;
   logic [31:0] addr, store_data, load_data, mem_addr, mem_write_data, mem_read_data;

   mem_access_unit #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .opcode(opcode), .addr(addr),
      .store_data(store_data), .stall(stall), .load_data(load_data), .load_valid(load_valid),
      .mem_fault(mem_fault), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
      .sig_mem_read(sig_mem_read), .sig_mem_write(sig_mem_write), .mem_read_data(mem_read_data)
   );

   logic [31:0] mem [0:255];
   assign mem_read_data = mem[mem_addr[7:0]];
   always @(posedge clk) if (sig_mem_write) mem[mem_addr[7:0]] <= mem_write_data;

   logic [7:0]  ref_b [0:1023];
   logic [31:0] init0;
   int checks = 0, errors = 0;

   logic        chk_en, chk_stall, exp_rst, exp_stall, exp_rd, exp_wr, exp_lv, exp_fault, exp_ld_chk;
   logic [31:0] exp_addr, exp_wdata, exp_ld;
   logic        nxt_lv, nxt_fault, nxt_ld_chk;
   logic [31:0] nxt_ld;
   bit          pend_sub;
   int          pend_a, pend_sz;
   logic [31:0] pend_sd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int op_size(input logic [5:0] op);
      case (op)
         LB, LBU, SB: return 1;
         LH, LHU, SH: return 2;
         LW, SW:      return 4;
         default:     return 0;
      endcase
   endfunction

   function automatic logic [31:0] ref_word(input int widx);
      return {ref_b[4*widx], ref_b[4*widx+1], ref_b[4*widx+2], ref_b[4*widx+3]};
   endfunction

   function automatic logic [7:0] st_byte(input int sz, input int k, input logic [31:0] sd);
      logic [31:0] s;
      s = sd >> (8 * (sz - 1 - k));
      return s[7:0];
   endfunction

   function automatic logic [31:0] merged_word(input int a, input int sz, input logic [31:0] sd);
      logic [7:0] b [4];
      int base;
      base = a - (a % 4);
      for (int k = 0; k < 4; k++) b[k] = ref_b[base + k];
      for (int k = 0; k < sz; k++) b[(a % 4) + k] = st_byte(sz, k, sd);
      return {b[0], b[1], b[2], b[3]};
   endfunction

   task automatic commit_store(input int a, input int sz, input logic [31:0] sd);
      for (int k = 0; k < sz; k++) ref_b[a + k] = st_byte(sz, k, sd);
   endtask

   function automatic logic [31:0] load_value(input logic [5:0] op, input int a);
      logic [31:0] v;
      int sz;
      sz = op_size(op);
      v = 0;
      for (int k = 0; k < sz; k++) v = (v << 8) | {24'h0, ref_b[a + k]};
      if (op == LB && v[7])  v = v | 32'hFFFFFF00;
      if (op == LH && v[15]) v = v | 32'hFFFF0000;
      return v;
   endfunction

   // One clock cycle of stimulus; predicts this cycle's strobes and next cycle's registered outputs.
   task automatic cyc(input logic v, input logic [5:0] op, input logic [31:0] a,
                      input logic [31:0] sd, input logic rst);
      int sz, ai, c_a, c_sz;
      bit do_commit;
      logic [31:0] c_sd;
      req_valid = v; opcode = op; addr = a; store_data = sd; reset = rst;
      exp_rd = 0; exp_wr = 0; exp_addr = 0; exp_wdata = 0; exp_rst = rst;
      exp_stall = pend_sub; chk_stall = !rst;
      nxt_lv = 0; nxt_fault = 0; nxt_ld = exp_ld; nxt_ld_chk = 0;
      do_commit = 0; c_a = 0; c_sz = 0; c_sd = 0;
      ai = int'(a[9:0]);
      if (rst) begin
         pend_sub = 0; nxt_ld = 0; nxt_ld_chk = 1;
      end else if (pend_sub) begin
         exp_wr = 1; exp_addr = pend_a / 4; exp_wdata = merged_word(pend_a, pend_sz, pend_sd);
         do_commit = 1; c_a = pend_a; c_sz = pend_sz; c_sd = pend_sd; pend_sub = 0;
      end else if (v) begin
         sz = op_size(op);
         if (sz != 0) begin
            if (a[31:10] != 0 || (int'(a[1:0]) % sz) != 0) nxt_fault = 1;
            else if (op == SW) begin
               exp_wr = 1; exp_addr = ai / 4; exp_wdata = sd;
               do_commit = 1; c_a = ai; c_sz = 4; c_sd = sd;
            end else if (op == SB || op == SH) begin
               exp_rd = 1; exp_addr = ai / 4;
               pend_sub = 1; pend_a = ai; pend_sz = sz; pend_sd = sd;
            end else begin
               exp_rd = 1; exp_addr = ai / 4;
               nxt_lv = 1; nxt_ld = load_value(op, ai); nxt_ld_chk = 1;
            end
         end
      end
      @(posedge clk);
      if (do_commit) commit_store(c_a, c_sz, c_sd);
      #1;
      exp_lv = nxt_lv; exp_fault = nxt_fault; exp_ld = nxt_ld; exp_ld_chk = nxt_ld_chk;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         if (chk_stall) chk("stall", {31'h0, stall}, {31'h0, exp_stall});
         chk("sig_mem_read", {31'h0, sig_mem_read}, {31'h0, exp_rd});
         chk("sig_mem_write", {31'h0, sig_mem_write}, {31'h0, exp_wr});
         chk("load_valid", {31'h0, load_valid}, {31'h0, exp_lv});
         chk("mem_fault", {31'h0, mem_fault}, {31'h0, exp_fault});
         if (exp_ld_chk) chk("load_data", load_data, exp_ld);
         if (exp_rd || exp_wr || exp_rst) chk("mem_addr", mem_addr, exp_addr);
         if (exp_wr || exp_rst) chk("mem_write_data", mem_write_data, exp_wdata);
      end
   end

   initial begin
      int bad;
      logic [31:0] w;
      chk_en = 0; pend_sub = 0; pend_a = 0; pend_sz = 0; pend_sd = 0;
      reset = 1; req_valid = 0; opcode = 0; addr = 0; store_data = 0;
      exp_rst = 1; exp_stall = 0; exp_rd = 0; exp_wr = 0; exp_lv = 0; exp_fault = 0;
      exp_ld = 0; exp_ld_chk = 1; exp_addr = 0; exp_wdata = 0; chk_stall = 0;
      for (int i = 0; i < 256; i++) begin
         w = (i * 32'h01030507) ^ 32'hA5A5A5A5;
         if (i == 5) w = 32'h11223344;
         if (i == 6) w = 32'h80FF7F00;
         mem[i] = w;
         for (int k = 0; k < 4; k++) ref_b[4*i + k] = w[31 - 8*k -: 8];
      end
      init0 = mem[0];
      @(posedge clk); #1;
      chk_en = 1;
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);

      cyc(1, LB, 32'h16, 0, 0);  chk("lb_0x16", load_data, 32'h00000033);
      cyc(1, LBU, 32'h14, 0, 0); chk("lbu_0x14", load_data, 32'h00000011);
      cyc(1, LH, 32'h18, 0, 0);  chk("lh_0x18", load_data, 32'hFFFF80FF);
      cyc(1, LHU, 32'h18, 0, 0); chk("lhu_0x18", load_data, 32'h000080FF);
      cyc(1, LB, 32'h1A, 0, 0);  chk("lb_0x1a", load_data, 32'h0000007F);

      cyc(1, SB, 32'h15, 32'h000000AB, 0);
      cyc(1, SB, 32'h15, 32'h000000AB, 0);
      chk("sb_word5", mem[5], 32'h11AB3344);
      cyc(1, LW, 32'h14, 0, 0);  chk("lw_after_sb", load_data, 32'h11AB3344);

      cyc(1, SW, 32'h14, 32'h11223344, 0);
      cyc(1, SH, 32'h16, 32'h0000BEEF, 0);
      cyc(1, LW, 32'h14, 0, 0);
      cyc(1, SW, 32'h18, 32'hCAFEF00D, 0);
      cyc(1, LW, 32'h16, 0, 0);
      chk("lw_0x16_fault", {31'h0, mem_fault}, 32'h1);
      chk("sh_word5", mem[5], 32'h1122BEEF);
      chk("sw_word6", mem[6], 32'hCAFEF00D);
      cyc(1, LH, 32'h16, 0, 0);  chk("lh_0x16", load_data, 32'hFFFFBEEF);

      cyc(1, LW, 32'h00000402, 0, 0);
      cyc(1, SW, 32'h00000400, 32'hDEADBEEF, 0);
      chk("oor_sw_word0", mem[0], init0);
      cyc(1, LH, 32'h17, 0, 0);
      cyc(1, SH, 32'h19, 32'h1234, 0);
      cyc(0, LW, 32'h14, 0, 0);
      cyc(1, 6'h00, 32'h14, 0, 0);
      cyc(1, LBU, 32'h13, 0, 0);

      cyc(1, SB, 32'h15, 32'h000000AB, 0);
      cyc(1, SB, 32'h15, 32'h000000AB, 1);
      cyc(0, 0, 0, 0, 0);
      chk("rst_rmw_word5", mem[5], 32'h1122BEEF);
      cyc(1, LB, 32'h17, 0, 0);  chk("lb_0x17", load_data, 32'hFFFFFFEF);

      cyc(1, SB, 32'h3FF, 32'h00000055, 0);
      cyc(1, SB, 32'h3FF, 32'h00000055, 0);
      cyc(1, LW, 32'h3FC, 0, 0);
      cyc(1, LHU, 32'h3FE, 0, 0);
      cyc(0, 0, 0, 0, 0);

      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_word(i)) bad++;
      chk("final_mem_mismatch_words", bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
